// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART command framing path: frame delimiters,
// error reason codes, frame-walker state encoding and byte arithmetic helpers.
package uart_frame_pkg;

    localparam logic [7:0] FRAME_HDR  = 8'hAA;
    localparam logic [7:0] FRAME_TAIL = 8'h55;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_SLOT    = 3'd1;
    localparam logic [2:0] ERR_CSUM    = 3'd2;
    localparam logic [2:0] ERR_TAIL    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_CMD  = 3'd1,
        S_SLOT = 3'd2,
        S_DH   = 3'd3,
        S_DL   = 3'd4,
        S_CSUM = 3'd5,
        S_TAIL = 3'd6
    } frame_state_e;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte watchdog: restarts on every received byte, counts while enabled and
// flags expiry once BYTE_TIMEOUT-1 idle cycles have elapsed since the last byte.
module uart_byte_timer #(
    parameter int BYTE_TIMEOUT = 52080
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A byte in the same cycle as the limit suppresses expiry.
    always_comb begin
        expire_o = en_i && !load_i && (cnt_q == CNT_LAST);
        if (load_i || !en_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_frame_ctrl.sv
// Assembles 7-byte command frames (AA CMD SLOT DH DL CSUM 55) from the UART byte
// stream, validates them and hands decoded commands out on a valid/ready port.
module uart_cmd_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int NUM_SLOTS    = 8,
    parameter int BYTE_TIMEOUT = 52080,
    parameter int SLOT_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [7:0]        cmd_code,
    output logic [SLOT_W-1:0] cmd_slot,
    output logic [15:0]       cmd_data,
    output logic              err_pulse,
    output logic [2:0]        err_code,
    output logic [7:0]        err_cnt,
    output logic              busy
);

    localparam logic [8:0] SLOT_LIM = 9'(NUM_SLOTS);

    frame_state_e state_q, state_d;
    logic [2:0]   fsm_err_s;
    logic [2:0]   err_s;
    logic         frame_ok_s;
    logic         expire_s;

    logic [7:0]        code_q, code_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [7:0]        dh_q, dh_d;
    logic [7:0]        dl_q, dl_d;
    logic [7:0]        sum_q, sum_d;

    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmd_code_q, cmd_code_d;
    logic [SLOT_W-1:0] cmd_slot_q, cmd_slot_d;
    logic [15:0]       cmd_data_q, cmd_data_d;
    logic              err_pulse_q, err_pulse_d;
    logic [2:0]        err_code_q, err_code_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              busy_q, busy_d;

    uart_byte_timer #(
        .BYTE_TIMEOUT(BYTE_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (rx_done),
        .en_i    (state_q != S_HDR),
        .expire_o(expire_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a header value seen mid-frame is ordinary payload.
    always_comb begin
        state_d    = state_q;
        fsm_err_s  = ERR_NONE;
        frame_ok_s = 1'b0;
        if (rx_done) begin
            case (state_q)
                S_HDR:  state_d = (rx_data == FRAME_HDR) ? S_CMD : S_HDR;
                S_CMD:  state_d = S_SLOT;
                S_SLOT: begin
                    if ({1'b0, rx_data} >= SLOT_LIM) begin
                        fsm_err_s = ERR_SLOT;
                        state_d   = S_HDR;
                    end else begin
                        state_d   = S_DH;
                    end
                end
                S_DH:   state_d = S_DL;
                S_DL:   state_d = S_CSUM;
                S_CSUM: begin
                    if (rx_data != sum_q) begin
                        fsm_err_s = ERR_CSUM;
                        state_d   = S_HDR;
                    end else begin
                        state_d   = S_TAIL;
                    end
                end
                S_TAIL: begin
                    state_d = S_HDR;
                    if (rx_data != FRAME_TAIL) begin
                        fsm_err_s = ERR_TAIL;
                    end else begin
                        frame_ok_s = 1'b1;
                    end
                end
                default: state_d = S_HDR;
            endcase
        end else if (expire_s) begin
            fsm_err_s = ERR_TIMEOUT;
            state_d   = S_HDR;
        end else begin
            state_d = state_q;
        end
    end

    // Field capture, handshake/overrun resolution and error bookkeeping.
    always_comb begin
        code_d      = code_q;
        slot_d      = slot_q;
        dh_d        = dh_q;
        dl_d        = dl_q;
        sum_d       = sum_q;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        cmd_slot_d  = cmd_slot_q;
        cmd_data_d  = cmd_data_q;
        err_s       = fsm_err_s;

        if (rx_done) begin
            case (state_q)
                S_CMD: begin
                    code_d = rx_data;
                    sum_d  = rx_data;
                end
                S_SLOT: begin
                    slot_d = rx_data[SLOT_W-1:0];
                    sum_d  = csum_add(sum_q, rx_data);
                end
                S_DH: begin
                    dh_d  = rx_data;
                    sum_d = csum_add(sum_q, rx_data);
                end
                S_DL: begin
                    dl_d  = rx_data;
                    sum_d = csum_add(sum_q, rx_data);
                end
                default: sum_d = sum_q;
            endcase
        end else begin
            sum_d = sum_q;
        end

        if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end else begin
            cmd_valid_d = cmd_valid_q;
        end

        // Acceptance in the completing cycle frees the slot for the new frame.
        if (frame_ok_s) begin
            if (cmd_valid_q && !cmd_ready) begin
                err_s = ERR_OVERRUN;
            end else begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = code_q;
                cmd_slot_d  = slot_q;
                cmd_data_d  = {dh_q, dl_q};
            end
        end else begin
            err_s = fsm_err_s;
        end

        err_pulse_d = (err_s != ERR_NONE);
        err_code_d  = err_s;
        if (err_pulse_d) begin
            err_cnt_d = sat_inc8(err_cnt_q);
        end else begin
            err_cnt_d = err_cnt_q;
        end
        busy_d = (state_d != S_HDR);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q      <= 8'h00;
            slot_q      <= '0;
            dh_q        <= 8'h00;
            dl_q        <= 8'h00;
            sum_q       <= 8'h00;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 8'h00;
            cmd_slot_q  <= '0;
            cmd_data_q  <= 16'h0000;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_cnt_q   <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            code_q      <= code_d;
            slot_q      <= slot_d;
            dh_q        <= dh_d;
            dl_q        <= dl_d;
            sum_q       <= sum_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_slot_q  <= cmd_slot_d;
            cmd_data_q  <= cmd_data_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_slot  = cmd_slot_q;
    assign cmd_data  = cmd_data_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_frame_ctrl.sv
// Scoreboard bench for uart_cmd_frame_ctrl: a byte-level frame model predicts
// commands and errors with their arrival cycle; a monitor matches DUT outputs.
module tb_uart_cmd_frame_ctrl;

    localparam int NS = 8;
    localparam int BT = 64;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_done = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid;
    logic [7:0]    cmd_code;
    logic [SW-1:0] cmd_slot;
    logic [15:0]   cmd_data;
    logic          err_pulse;
    logic [2:0]    err_code;
    logic [7:0]    err_cnt;
    logic          busy;

    uart_cmd_frame_ctrl #(.NUM_SLOTS(NS), .BYTE_TIMEOUT(BT), .SLOT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
        .cmd_slot(cmd_slot), .cmd_data(cmd_data), .err_pulse(err_pulse),
        .err_code(err_code), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { int code; int cnt; int at; } exp_err_t;
    typedef struct { int code; int slot; int data; int at; } exp_cmd_t;
    exp_err_t exp_err[$];
    exp_cmd_t exp_cmd[$];

    // Reference model state: bytes of the frame being collected, pending command.
    logic [7:0] fbuf[$];
    bit         pend = 1'b0;
    int         nerr = 0;
    int         last_byte = 0;
    int         ready_pct = 100;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic model_err(input int code, input int at);
        nerr++;
        exp_err.push_back('{code, (nerr > 255) ? 255 : nerr, at});
    endtask

    // One clock of stimulus plus the model's view of that cycle.
    task automatic drive_cycle(input bit v, input logic [7:0] b);
        int  n;
        int  ecode;
        int  s;
        bit  good;
        bit  acc;
        n = cyc;
        rx_done   = v;
        rx_data   = v ? b : 8'($urandom);
        cmd_ready = ($urandom_range(0, 99) < ready_pct);
        acc   = pend && cmd_ready;
        ecode = 0;
        good  = 1'b0;
        if (v) begin
            last_byte = n;
            if (fbuf.size() == 0) begin
                if (b == 8'hAA) fbuf.push_back(b);
            end else begin
                fbuf.push_back(b);
                if (fbuf.size() == 3 && int'(b) >= NS) ecode = 1;
                if (fbuf.size() == 6) begin
                    s = fbuf[1] + fbuf[2] + fbuf[3] + fbuf[4];
                    if ((s % 256) != int'(b)) ecode = 2;
                end
                if (fbuf.size() == 7) begin
                    if (b != 8'h55) ecode = 3;
                    else good = 1'b1;
                end
                if (ecode != 0) begin
                    model_err(ecode, n + 1);
                    fbuf.delete();
                end else if (good) begin
                    if (pend && !cmd_ready) begin
                        model_err(5, n + 1);
                    end else begin
                        exp_cmd.push_back('{int'(fbuf[1]), int'(fbuf[2]) % (1 << SW),
                                            {fbuf[3], fbuf[4]}, n + 1});
                        pend = 1'b1;
                        acc  = 1'b0;
                    end
                    fbuf.delete();
                end
            end
        end else if (fbuf.size() > 0 && n == last_byte + BT) begin
            model_err(4, n + 1);
            fbuf.delete();
        end
        if (acc) pend = 1'b0;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) drive_cycle(1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        drive_cycle(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] s, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] cs, input logic [7:0] tl,
                              input int gpos, input int glen);
        logic [7:0] fr[7];
        fr = '{8'hAA, c, s, dh, dl, cs, tl};
        for (int i = 0; i < 7; i++) send(fr[i], (i == gpos) ? glen : $urandom_range(0, 1));
    endtask

    function automatic logic [7:0] csum(input logic [7:0] c, input logic [7:0] s,
                                        input logic [7:0] dh, input logic [7:0] dl);
        int t;
        t = c + s + dh + dl;
        return 8'(t % 256);
    endfunction

    task automatic do_reset();
        chk("err_queue_at_reset", exp_err.size(), 0);
        chk("cmd_queue_at_reset", exp_cmd.size(), 0);
        rst_n = 1'b0;
        rx_done = 1'b0;
        cmd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fbuf.delete();
        exp_err.delete();
        exp_cmd.delete();
        pend = 1'b0;
        nerr = 0;
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_code", cmd_code, 0);
        chk("rst_cmd_slot", cmd_slot, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
    endtask

    // Monitor: matches each presented command / error pulse against the scoreboard.
    initial begin
        logic          pv;
        logic          pa;
        logic [7:0]    pcode;
        logic [SW-1:0] pslot;
        logic [15:0]   pdata;
        exp_err_t      e;
        exp_cmd_t      c;
        pv = 1'b0;
        pa = 1'b0;
        pcode = 8'h00;
        pslot = '0;
        pdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                pa = 1'b0;
            end else begin
                while (exp_err.size() > 0 && exp_err[0].at < cyc) begin
                    chk("err_missing_at", cyc, exp_err[0].at);
                    void'(exp_err.pop_front());
                end
                while (exp_cmd.size() > 0 && exp_cmd[0].at < cyc) begin
                    chk("cmd_missing_at", cyc, exp_cmd[0].at);
                    void'(exp_cmd.pop_front());
                end
                if (err_pulse) begin
                    if (exp_err.size() == 0) begin
                        chk("err_unexpected", err_pulse, 0);
                    end else begin
                        e = exp_err.pop_front();
                        chk("err_code", err_code, e.code);
                        chk("err_cnt", err_cnt, e.cnt);
                        chk("err_cycle", cyc, e.at);
                    end
                end
                if (cmd_valid && (!pv || pa)) begin
                    if (exp_cmd.size() == 0) begin
                        chk("cmd_unexpected", cmd_valid, 0);
                    end else begin
                        c = exp_cmd.pop_front();
                        chk("cmd_code", cmd_code, c.code);
                        chk("cmd_slot", cmd_slot, c.slot);
                        chk("cmd_data", cmd_data, c.data);
                        chk("cmd_cycle", cyc, c.at);
                    end
                end else if (cmd_valid) begin
                    chk("hold_code", cmd_code, pcode);
                    chk("hold_slot", cmd_slot, pslot);
                    chk("hold_data", cmd_data, pdata);
                end else if (pv && !pa) begin
                    chk("valid_dropped", cmd_valid, 1);
                end
                pv = cmd_valid;
                pa = cmd_valid && cmd_ready;
                pcode = cmd_code;
                pslot = cmd_slot;
                pdata = cmd_data;
            end
        end
    end

    initial begin
        int kind, gpos, glen;
        logic [7:0] c, s, dh, dl, cs, tl;

        // Reset and idle noise
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        ready_pct = 100;
        send(8'h13, 1);
        send(8'h55, 1);
        idle(4);
        chk("idle_busy", busy, 0);

        // Good frame
        send(8'hAA, 1);
        chk("busy_in_frame", busy, 1);
        send(8'h01, 0); send(8'h03, 0); send(8'h12, 0);
        send(8'h34, 0); send(8'h4A, 0); send(8'h55, 0);
        idle(4);

        // Slot, checksum, tail errors
        send(8'hAA, 0); send(8'h01, 0); send(8'h09, 0);
        idle(3);
        send_frame(8'h01, 8'h03, 8'h12, 8'h34, 8'h4B, 8'h55, 0, 0);
        idle(3);
        chk("busy_after_csum_err", busy, 0);
        send_frame(8'h01, 8'h03, 8'h12, 8'h34, 8'h4A, 8'h66, 0, 0);
        idle(3);

        // Timeout, then byte landing exactly at the limit, then good frame
        send(8'hAA, 0); send(8'h01, 0);
        idle(BT + 3);
        chk("busy_after_timeout", busy, 0);
        send_frame(8'h02, 8'h07, 8'hAA, 8'h10, csum(8'h02, 8'h07, 8'hAA, 8'h10), 8'h55, 3, BT - 1);
        send_frame(8'h05, 8'h00, 8'hFF, 8'hFF, csum(8'h05, 8'h00, 8'hFF, 8'hFF), 8'h55, 0, 0);
        idle(3);

        // Backpressure and overrun
        ready_pct = 0;
        send_frame(8'h11, 8'h01, 8'h22, 8'h33, csum(8'h11, 8'h01, 8'h22, 8'h33), 8'h55, 0, 0);
        send_frame(8'h44, 8'h02, 8'h55, 8'h66, csum(8'h44, 8'h02, 8'h55, 8'h66), 8'h55, 0, 0);
        idle(3);
        chk("held_valid", cmd_valid, 1);
        chk("held_first_code", cmd_code, 8'h11);
        ready_pct = 100;
        idle(1);
        chk("valid_drop_after_accept", cmd_valid, 0);
        ready_pct = 0;
        send_frame(8'h21, 8'h04, 8'h01, 8'h02, csum(8'h21, 8'h04, 8'h01, 8'h02), 8'h55, 0, 0);
        send(8'hAA, 0); send(8'h31, 0); send(8'h05, 0); send(8'h03, 0); send(8'h04, 0);
        send(csum(8'h31, 8'h05, 8'h03, 8'h04), 0);
        ready_pct = 100;
        send(8'h55, 0);
        idle(2);
        chk("replace_code", cmd_code, 8'h31);
        idle(3);

        // Randomised frames
        for (int f = 0; f < 300; f++) begin
            case ($urandom_range(0, 3))
                0: ready_pct = 0;
                1: ready_pct = 30;
                2: ready_pct = 70;
                default: ready_pct = 100;
            endcase
            kind = $urandom_range(0, 9);
            c  = 8'($urandom);
            s  = 8'($urandom_range(0, NS - 1));
            dh = 8'($urandom);
            dl = 8'($urandom);
            cs = csum(c, s, dh, dl);
            tl = 8'h55;
            gpos = 0;
            glen = 0;
            if (kind == 0) s = 8'($urandom_range(NS, 255));
            if (kind == 1) cs = cs ^ 8'($urandom_range(1, 255));
            if (kind == 2) tl = 8'h55 ^ 8'($urandom_range(1, 255));
            if (kind == 3) send(8'($urandom), 0);
            if (kind == 4) begin gpos = $urandom_range(1, 6); glen = BT + $urandom_range(0, 3); end
            if (kind == 5) begin gpos = $urandom_range(1, 6); glen = BT - 1; end
            send_frame(c, s, dh, dl, cs, tl, gpos, glen);
        end
        ready_pct = 100;
        idle(BT + 5);

        // Error counter saturation
        for (int f = 0; f < 260; f++) begin
            send_frame(8'h01, 8'h03, 8'h12, 8'h34, 8'h4B, 8'h55, 0, 0);
        end
        idle(3);
        chk("err_cnt_saturated", err_cnt, 255);

        // Reset in the middle of a frame, then a good frame
        send(8'hAA, 0); send(8'h01, 0); send(8'h03, 0);
        chk("busy_before_mid_reset", busy, 1);
        do_reset();
        idle(2);
        send_frame(8'h09, 8'h06, 8'hBE, 8'hEF, csum(8'h09, 8'h06, 8'hBE, 8'hEF), 8'h55, 0, 0);
        idle(BT + 10);

        chk("err_queue_drained", exp_err.size(), 0);
        chk("cmd_queue_drained", exp_cmd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
